// File: rtl/bus_master_pkg.sv
// Shared types and defaults for the req/ack bus initiator.
package bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/bus_master_if.sv
// Local command/response port plus the req/ack bus, as seen by bus_master (master)
// and by whatever drives commands and answers requests (slave).
interface bus_master_if
  import bus_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, ack, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, req, cmd, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, ack, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, req, cmd, addr, wdata
  );
endinterface

// File: rtl/bus_master_timer.sv
// Request timeout counter: cleared outside REQ, counts REQ cycles, flags the last allowed one.
module bus_master_timer
  import bus_master_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (enable && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the number of completed REQ cycles, so LIMIT-1 marks the LIMIT-th one
  assign expired = (cnt == 8'(LIMIT - 1));
endmodule

// File: rtl/bus_master.sv
// Single-outstanding req/ack bus initiator with a valid/ready command port.
// Optional request timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic          clk,
  input logic          rst,
  bus_master_if.master bus
);
  state_t            state;
  logic              req_q;
  logic              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timeout;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("bus_master: TIMEOUT_CYC must be within 2..255");
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_master_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .enable (state == REQ),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      cmd_q       <= CMD_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state   <= REQ;
            req_q   <= 1'b1;
            cmd_q   <= bus.cmd_write;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
          end
        end
        REQ: begin
          // ack has priority over a timeout expiring in the same cycle
          if (bus.ack) begin
            state       <= RESP;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (cmd_q == CMD_READ) ? bus.rdata : '0;
            rsp_err_q   <= 1'b0;
          end else if (timeout) begin
            state       <= RESP;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cmd_ready must read 0 during reset, so it is gated by rst directly
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.req       = req_q;
  assign bus.cmd       = cmd_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: responses are matched against expectations queued at issue.
module tb_bus_master;
  import bus_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  bit          resp_en = 1'b1;
  int          resp_delay = 1;
  bit          stray_ack = 1'b0;
  bit          ack_now = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // responder: acks in the resp_delay-th REQ cycle; writes see garbage rdata
  initial begin : responder
    int req_cycles;
    req_cycles = 0;
    bus.ack    = 1'b0;
    bus.rdata  = '0;
    forever begin
      @(negedge clk);
      bus.ack = stray_ack;
      if (bus.req) begin
        req_cycles++;
        if ((resp_en && req_cycles == resp_delay) || ack_now) begin
          ack_now   = 1'b0;
          bus.ack   = 1'b1;
          bus.rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0_BAD0;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   low_cnt;
    bit   seen;
    logic prev_req;
    low_cnt  = 0;
    seen     = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        chk("rsp_req_low", 64'(bus.req), 64'h0);
        if (sb.size() == 0) begin
          chk("spurious_rsp", 64'h1, 64'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
      if (bus.req && !prev_req) begin
        if (seen) chk("req_gap_ge2", 64'(low_cnt >= 2), 64'h1);
        seen = 1'b1;
      end
      low_cnt  = bus.req ? 0 : low_cnt + 1;
      prev_req = bus.req;
    end
  end

  // called at a negedge; returns at the negedge of the first REQ cycle
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input bit hold);
    exp_t e;
    int   n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 200), 64'h1);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    chk("req_after_accept", 64'(bus.req), 64'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 64'(n < 300), 64'h1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    chk("rst_req", 64'(bus.req), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_cmd", 64'(bus.cmd), 64'h0);
    chk("rst_addr", 64'(bus.addr), 64'h0);
    chk("rst_wdata", 64'(bus.wdata), 64'h0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.cmd_ready), 64'h1);
    @(negedge clk);

    // single read, ack in first REQ cycle
    resp_delay = 1;
    rd_q.push_back(32'h5);
    send(CMD_READ, 32'h10, 32'h0, 32'h5, 1'b0, 1'b0);
    chk("read_cmd", 64'(bus.cmd), 64'h0);
    chk("read_addr", 64'(bus.addr), 64'h10);
    wait_idle();

    // write held for three REQ cycles
    resp_delay = 3;
    send(CMD_WRITE, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (bus.req && n < 20) begin
      chk("wr_cmd_stable", 64'(bus.cmd), 64'h1);
      chk("wr_addr_stable", 64'(bus.addr), 64'h20);
      chk("wr_wdata_stable", 64'(bus.wdata), 64'hDEAD_BEEF);
      @(negedge clk);
      n++;
    end
    chk("wr_req_cycles", 64'(n), 64'd3);
    wait_idle();
    chk("hold_cmd", 64'(bus.cmd), 64'h1);
    chk("hold_addr", 64'(bus.addr), 64'h20);
    chk("hold_wdata", 64'(bus.wdata), 64'hDEAD_BEEF);

    // back-to-back reads with cmd_valid held
    resp_delay = 1;
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h1);
    rd_q.push_back(32'h2);
    send(CMD_READ, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
    send(CMD_READ, 32'h104, 32'h0, 32'h1, 1'b0, 1'b1);
    send(CMD_READ, 32'h108, 32'h0, 32'h2, 1'b0, 1'b0);
    wait_idle();

    // no ack at all
    resp_en = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    send(CMD_READ, 32'h30, 32'h0, 32'h0, 1'b1, 1'b0);
    n = 1;
    @(negedge clk);
    while (bus.req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_req_cycles", 64'(n), 64'(TO));
    wait_idle();
`else
    rd_q.push_back(32'h77);
    send(CMD_READ, 32'h30, 32'h0, 32'h77, 1'b0, 1'b0);
    repeat (99) @(negedge clk);
    chk("req_held_no_timeout", 64'(bus.req), 64'h1);
    ack_now = 1'b1;
    wait_idle();
`endif
    resp_en = 1'b1;

    // ack lands in the same cycle the timeout would expire
    resp_delay = TO;
    rd_q.push_back(32'hA5);
    send(CMD_READ, 32'h40, 32'h0, 32'hA5, 1'b0, 1'b0);
    wait_idle();

    // stray ack while idle
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_rsp", 64'(bus.rsp_valid), 64'h0);
      chk("stray_not_busy", 64'(bus.busy), 64'h0);
    end
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-REQ discards the transaction
    resp_en = 1'b0;
    send(CMD_READ, 32'h50, 32'h0, 32'h0, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_low", 64'(bus.req), 64'h0);
    chk("rst_mid_not_busy", 64'(bus.busy), 64'h0);
    chk("rst_mid_ready", 64'(bus.cmd_ready), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    resp_delay = 2;
    rd_q.push_back(32'h33);
    @(negedge clk);
    send(CMD_READ, 32'h60, 32'h0, 32'h33, 1'b0, 1'b0);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
